// File: rtl/sha3_absorb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sha3_pkg
// Shared types and constants for the SHA3 absorb sequencer:
//   - sha3_state_t     : sequencer state encoding
//   - SHA3_DOMAIN_PAD  : first pad byte (SHA3 domain bits + leading 1)
//   - SHA3_FINAL_PAD   : trailing pad bit in the top byte of the last rate word
//   - SHA3_*_RATE_WORDS: rate sizes in 32-bit words for the four SHA3 widths
//   - sha3_clamp_bytes : saturates a beat byte count to 4
// -----------------------------------------------------------------------------
package sha3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABSORB = 3'd1,
        ST_PERM   = 3'd2,
        ST_PAD    = 3'd3,
        ST_FINAL  = 3'd4,
        ST_DONE   = 3'd5
    } sha3_state_t;

    localparam logic [7:0] SHA3_DOMAIN_PAD = 8'h06;
    localparam logic [7:0] SHA3_FINAL_PAD  = 8'h80;

    localparam int SHA3_224_RATE_WORDS = 36;
    localparam int SHA3_256_RATE_WORDS = 34;
    localparam int SHA3_384_RATE_WORDS = 26;
    localparam int SHA3_512_RATE_WORDS = 18;

    // Byte counts above 4 are treated as a full word.
    function automatic logic [2:0] sha3_clamp_bytes(input logic [2:0] b);
        return (b > 3'd4) ? 3'd4 : b;
    endfunction

endpackage

// File: rtl/sha3_absorb_ctrl_if.sv
// -----------------------------------------------------------------------------
// sha3_absorb_ctrl_if
// Bundles the message stream, the rate-XOR write port and the permutation /
// digest handshake between the register front end, the sequencer and the core.
//   slave  : sequencer view (sha3_absorb_ctrl)
//   master : environment view (front end + Keccak core, or a testbench)
// Optional: SHA3_CTRL_ABORT_EN adds the abort input.
// -----------------------------------------------------------------------------
interface sha3_absorb_ctrl_if #(
    parameter int RATE_WORDS = 34
);
    localparam int AW = $clog2(RATE_WORDS);

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic [2:0]    in_bytes;
    logic          xor_we;
    logic [AW-1:0] xor_addr;
    logic [31:0]   xor_data;
    logic          perm_start;
    logic          perm_done;
    logic          state_clr;
    logic          digest_valid;
    logic          digest_ack;
`ifdef SHA3_CTRL_ABORT_EN
    logic          abort;
`endif

    modport slave (
`ifdef SHA3_CTRL_ABORT_EN
        input  abort,
`endif
        input  in_valid, in_data, in_last, in_bytes, perm_done, digest_ack,
        output in_ready, xor_we, xor_addr, xor_data, perm_start, state_clr,
               digest_valid
    );

    modport master (
`ifdef SHA3_CTRL_ABORT_EN
        output abort,
`endif
        output in_valid, in_data, in_last, in_bytes, perm_done, digest_ack,
        input  in_ready, xor_we, xor_addr, xor_data, perm_start, state_clr,
               digest_valid
    );

endinterface

// File: rtl/sha3_pad_word.sv
// -----------------------------------------------------------------------------
// sha3_pad_word
// Combinational builder for the final message word of a SHA3 message.
//   i_data      : raw beat data, little-endian bytes
//   i_nbytes    : valid bytes in the beat (0..4, already clamped)
//   i_last_word : the word lands on the last rate word
//   o_word      : word to XOR into the state
// With i_nbytes < 4 the unused bytes are zeroed, 0x06 is XORed into byte
// i_nbytes, and 0x80 into byte 3 when this is the last rate word. With
// i_nbytes == 4 the word passes through untouched (padding follows later).
// -----------------------------------------------------------------------------
module sha3_pad_word
    import sha3_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_nbytes,
    input  logic        i_last_word,
    output logic [31:0] o_word
);

    always_comb begin
        o_word = i_data;
        if (i_nbytes < 3'd4) begin
            for (int b = 0; b < 4; b++) begin
                if (b >= int'(i_nbytes)) o_word[8*b +: 8] = 8'h00;
            end
            o_word[{i_nbytes[1:0], 3'b000} +: 8] =
                o_word[{i_nbytes[1:0], 3'b000} +: 8] ^ SHA3_DOMAIN_PAD;
            if (i_last_word) o_word[31:24] = o_word[31:24] ^ SHA3_FINAL_PAD;
        end
    end

endmodule

// File: rtl/sha3_absorb_ctrl.sv
// -----------------------------------------------------------------------------
// sha3_absorb_ctrl
// Sequencer between the register front end and the Keccak-f[1600] core.
// Streams 32-bit message words into the rate part of the state, applies
// SHA3 padding (0x06 ... 0x80), fires the permutation per full block and
// after padding, and holds digest_valid until software acknowledges.
// Ports:
//   ACLK        : clock, rising edge
//   ARESET      : asynchronous active-high reset
//   bus (slave) : in_* message stream, xor_* rate write, perm_start/perm_done,
//                 state_clr, digest_valid/digest_ack (+ abort, see below)
// Parameter RATE_WORDS: rate in 32-bit words, 2..42 (34 = SHA3-256).
// Optional: define SHA3_CTRL_ABORT_EN to enable the abort input.
// -----------------------------------------------------------------------------
module sha3_absorb_ctrl
    import sha3_pkg::*;
#(
    parameter int RATE_WORDS = SHA3_256_RATE_WORDS
) (
    input  logic              ACLK,
    input  logic              ARESET,
    sha3_absorb_ctrl_if.slave bus
);

    localparam int            AW       = $clog2(RATE_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(RATE_WORDS - 1);

    sha3_state_t   r_state;
    logic [AW-1:0] r_word_cnt;
    logic          r_xor_we;
    logic [AW-1:0] r_xor_addr;
    logic [31:0]   r_xor_data;
    logic          r_perm_start;
    logic          r_started;      // perm_start already issued in PERM/FINAL
    logic          r_state_clr;
    logic          r_digest_valid;
    logic          r_live;         // low during reset and its release cycle
    logic          r_pad_pending;  // PAD still owed after a full-block PERM
    logic          r_need_06;      // PAD must still write the 0x06 word
    logic          r_abort_pend;

    logic [2:0]    w_nbytes;
    logic          w_last_word;
    logic [31:0]   w_pad_word;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_abort;
    logic          w_perm_ack;
    logic          w_clear;

`ifdef SHA3_CTRL_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_nbytes    = sha3_clamp_bytes(bus.in_bytes);
    assign w_last_word = (r_word_cnt == LAST_IDX);

    // Ready is held off during the state_clr cycle so a new message never
    // starts before the core has zeroed its state.
    assign w_in_ready = r_live && !r_state_clr &&
                        ((r_state == ST_IDLE) || (r_state == ST_ABSORB));
    assign w_accept   = w_in_ready && bus.in_valid && !w_abort;
    assign w_perm_ack = r_started && bus.perm_done;

    sha3_pad_word u_pad (
        .i_data      (bus.in_data),
        .i_nbytes    (w_nbytes),
        .i_last_word (w_last_word),
        .o_word      (w_pad_word)
    );

    // Every path back to IDLE that zeroes the core state.
    always_comb begin
        w_clear = 1'b0;
        case (r_state)
            ST_IDLE, ST_ABSORB, ST_PAD: w_clear = w_abort;
            ST_DONE:                    w_clear = w_abort || bus.digest_ack;
            ST_PERM, ST_FINAL:          w_clear = w_perm_ack && (w_abort || r_abort_pend);
            default:                    w_clear = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state        <= ST_IDLE;
            r_word_cnt     <= '0;
            r_xor_we       <= 1'b0;
            r_xor_addr     <= '0;
            r_xor_data     <= '0;
            r_perm_start   <= 1'b0;
            r_started      <= 1'b0;
            r_state_clr    <= 1'b0;
            r_digest_valid <= 1'b0;
            r_live         <= 1'b0;
            r_pad_pending  <= 1'b0;
            r_need_06      <= 1'b0;
            r_abort_pend   <= 1'b0;
        end else begin
            r_live       <= 1'b1;
            r_xor_we     <= 1'b0;
            r_perm_start <= 1'b0;
            r_state_clr  <= 1'b0;
            if (w_clear) begin
                r_state        <= ST_IDLE;
                r_state_clr    <= 1'b1;
                r_word_cnt     <= '0;
                r_started      <= 1'b0;
                r_pad_pending  <= 1'b0;
                r_need_06      <= 1'b0;
                r_abort_pend   <= 1'b0;
                r_digest_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_ABSORB: begin
                        if (w_accept) begin
                            r_xor_we   <= 1'b1;
                            r_xor_addr <= r_word_cnt;
                            if (!bus.in_last) begin
                                r_xor_data <= bus.in_data;
                                if (w_last_word) begin
                                    r_word_cnt <= '0;
                                    r_state    <= ST_PERM;
                                end else begin
                                    r_word_cnt <= r_word_cnt + 1'b1;
                                    r_state    <= ST_ABSORB;
                                end
                            end else begin
                                r_xor_data <= w_pad_word;
                                if (w_nbytes == 3'd4) begin
                                    // Full final word: the 0x06 goes into the
                                    // next word, after a block permutation if
                                    // this word closed the block.
                                    r_need_06 <= 1'b1;
                                    if (w_last_word) begin
                                        r_word_cnt    <= '0;
                                        r_pad_pending <= 1'b1;
                                        r_state       <= ST_PERM;
                                    end else begin
                                        r_word_cnt <= r_word_cnt + 1'b1;
                                        r_state    <= ST_PAD;
                                    end
                                end else begin
                                    r_need_06 <= 1'b0;
                                    r_state   <= w_last_word ? ST_FINAL : ST_PAD;
                                end
                            end
                        end
                    end

                    ST_PAD: begin
                        r_xor_we <= 1'b1;
                        if (r_need_06) begin
                            r_xor_addr <= r_word_cnt;
                            r_xor_data <= {(w_last_word ? SHA3_FINAL_PAD : 8'h00),
                                           16'h0000, SHA3_DOMAIN_PAD};
                            r_need_06  <= 1'b0;
                            if (w_last_word) r_state <= ST_FINAL;
                        end else begin
                            r_xor_addr <= LAST_IDX;
                            r_xor_data <= {SHA3_FINAL_PAD, 24'h000000};
                            r_state    <= ST_FINAL;
                        end
                    end

                    ST_PERM, ST_FINAL: begin
                        r_abort_pend <= r_abort_pend | w_abort;
                        // Start is issued one cycle into the state so it
                        // always trails the block's last registered XOR.
                        if (!r_started) begin
                            r_perm_start <= 1'b1;
                            r_started    <= 1'b1;
                        end else if (bus.perm_done) begin
                            r_started <= 1'b0;
                            if (r_state == ST_FINAL) begin
                                r_state        <= ST_DONE;
                                r_digest_valid <= 1'b1;
                            end else if (r_pad_pending) begin
                                r_pad_pending <= 1'b0;
                                r_state       <= ST_PAD;
                            end else begin
                                r_state <= ST_ABSORB;
                            end
                        end
                    end

                    ST_DONE: begin
                        r_digest_valid <= 1'b1;
                    end

                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.xor_we       = r_xor_we;
    assign bus.xor_addr     = r_xor_addr;
    assign bus.xor_data     = r_xor_data;
    assign bus.perm_start   = r_perm_start;
    assign bus.state_clr    = r_state_clr;
    assign bus.digest_valid = r_digest_valid;

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
module tb_sha3_absorb_ctrl;

    localparam int RW = 34;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha3_absorb_ctrl_if #(.RATE_WORDS(RW)) bus ();

    sha3_absorb_ctrl #(.RATE_WORDS(RW)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
    );

    int n_tot = 0;
    int n_bad = 0;

    // write log and pulse counters, sampled on the falling edge
    int          wa[$];
    logic [31:0] wd[$];
    int          n_start = 0;
    int          cyc = 0;
    int          last_xor_cyc = 0;
    int          start_cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus.xor_we) begin
                wa.push_back(int'(bus.xor_addr));
                wd.push_back(bus.xor_data);
                last_xor_cyc = cyc;
            end
            if (bus.perm_start) begin
                n_start   = n_start + 1;
                start_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        n_start = 0;
    endtask

    task automatic chk_wr(input string tag, input int idx, input int addr, input logic [31:0] data);
        if (idx < wa.size()) begin
            chk({tag, "_addr"}, 64'(wa[idx]), 64'(addr));
            chk({tag, "_data"}, 64'(wd[idx]), 64'(data));
        end else begin
            chk({tag, "_missing"}, 64'(wa.size()), 64'(idx + 1));
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [2:0] nb, input logic last);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_bytes = nb;
        bus.in_last  = last;
        for (int k = 0; k < 200; k++) begin
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("beat_accept", 64'(ok), 64'd1);
        if (ok) tick();
        bus.in_valid = 1'b0;
    endtask

    // Waits for perm_start, holds perm_done off for dly cycles, then pulses it.
    // For the final permutation also checks digest_valid and the ack path.
    task automatic run_perm(input int dly, input bit is_final, input string tag);
        bit found = 0;
        bit rdy_bad = 0;
        int nx;
        for (int k = 0; k < 300; k++) begin
            if (bus.perm_start) begin
                found = 1;
                break;
            end
            tick();
        end
        chk({tag, "_start_seen"}, 64'(found), 64'd1);
        chk({tag, "_start_after_xor"}, 64'(start_cyc > last_xor_cyc), 64'd1);
        nx = wa.size();
        if (bus.in_ready) rdy_bad = 1;
        for (int k = 0; k < dly; k++) begin
            tick();
            if (bus.in_ready) rdy_bad = 1;
        end
        chk({tag, "_rdy_low"}, 64'(rdy_bad), 64'd0);
        bus.perm_done = 1'b1;
        if (is_final) chk({tag, "_dv_pre"}, 64'(bus.digest_valid), 64'd0);
        tick();
        bus.perm_done = 1'b0;
        chk({tag, "_no_xor_in_perm"}, 64'(wa.size()), 64'(nx));
        if (is_final) begin
            chk({tag, "_dv"}, 64'(bus.digest_valid), 64'd1);
            chk({tag, "_rdy_done"}, 64'(bus.in_ready), 64'd0);
            bus.digest_ack = 1'b1;
            tick();
            bus.digest_ack = 1'b0;
            chk({tag, "_clr"}, 64'(bus.state_clr), 64'd1);
            chk({tag, "_dv_fall"}, 64'(bus.digest_valid), 64'd0);
            tick();
            chk({tag, "_clr_once"}, 64'(bus.state_clr), 64'd0);
            chk({tag, "_rdy_rearm"}, 64'(bus.in_ready), 64'd1);
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.in_bytes   = '0;
        bus.perm_done  = 1'b0;
        bus.digest_ack = 1'b0;
`ifdef SHA3_CTRL_ABORT_EN
        bus.abort      = 1'b0;
`endif

        // reset state
        repeat (3) tick();
        chk("rst_rdy", 64'(bus.in_ready), 64'd0);
        chk("rst_we", 64'(bus.xor_we), 64'd0);
        chk("rst_start", 64'(bus.perm_start), 64'd0);
        chk("rst_clr", 64'(bus.state_clr), 64'd0);
        chk("rst_dv", 64'(bus.digest_valid), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_rdy", 64'(bus.in_ready), 64'd1);

        // empty message
        clear_log();
        send_beat(32'h0, 3'd0, 1'b1);
        run_perm(2, 1, "empty");
        chk("empty_nwr", 64'(wa.size()), 64'd2);
        chk_wr("empty_w0", 0, 0, 32'h0000_0006);
        chk_wr("empty_w1", 1, 33, 32'h8000_0000);
        chk("empty_nstart", 64'(n_start), 64'd1);

        // "abc" with junk above the valid bytes
        clear_log();
        send_beat(32'hFF63_6261, 3'd3, 1'b1);
        run_perm(0, 1, "abc");
        chk("abc_nwr", 64'(wa.size()), 64'd2);
        chk_wr("abc_w0", 0, 0, 32'h0663_6261);
        chk_wr("abc_w1", 1, 33, 32'h8000_0000);
        chk("abc_nstart", 64'(n_start), 64'd1);

        // 135 bytes: 0x80 merges into the last partial word, no PAD
        clear_log();
        for (int i = 0; i < 33; i++) send_beat(32'h1000_0000 + 32'(i), 3'd4, 1'b0);
        send_beat(32'h00AA_BBCC, 3'd3, 1'b1);
        run_perm(1, 1, "m135");
        chk("m135_nwr", 64'(wa.size()), 64'd34);
        chk_wr("m135_w0", 0, 0, 32'h1000_0000);
        chk_wr("m135_w32", 32, 32, 32'h1000_0020);
        chk_wr("m135_w33", 33, 33, 32'h86AA_BBCC);
        chk("m135_nstart", 64'(n_start), 64'd1);

        // 136 bytes: full block permutation with backpressure, then pad block
        clear_log();
        for (int i = 0; i < 34; i++) send_beat(32'h2000_0000 + 32'(i), 3'd4, i == 33);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        bus.in_bytes = 3'd4;
        bus.in_last  = 1'b0;
        run_perm(24, 0, "m136a");
        bus.in_valid = 1'b0;
        run_perm(1, 1, "m136b");
        chk("m136_nwr", 64'(wa.size()), 64'd36);
        chk_wr("m136_w33", 33, 33, 32'h2000_0021);
        chk_wr("m136_p0", 34, 0, 32'h0000_0006);
        chk_wr("m136_p1", 35, 33, 32'h8000_0000);
        chk("m136_nstart", 64'(n_start), 64'd2);

        // in_bytes > 4 acts as 4: pad word lands in word 1, 0x80 in word 33
        clear_log();
        send_beat(32'h4433_2211, 3'd7, 1'b1);
        run_perm(0, 1, "nb7");
        chk("nb7_nwr", 64'(wa.size()), 64'd3);
        chk_wr("nb7_w0", 0, 0, 32'h4433_2211);
        chk_wr("nb7_w1", 1, 1, 32'h0000_0006);

        // reset while in PERM: outputs drop immediately
        clear_log();
        for (int i = 0; i < 34; i++) send_beat(32'h3000_0000 + 32'(i), 3'd4, 1'b0);
        begin
            bit found = 0;
            for (int k = 0; k < 50; k++) begin
                if (bus.perm_start) begin
                    found = 1;
                    break;
                end
                tick();
            end
            chk("rstmid_start_seen", 64'(found), 64'd1);
        end
        rst = 1'b1;
        #1;
        chk("rstmid_start", 64'(bus.perm_start), 64'd0);
        chk("rstmid_rdy", 64'(bus.in_ready), 64'd0);
        chk("rstmid_dv", 64'(bus.digest_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rstmid_rdy_back", 64'(bus.in_ready), 64'd1);

`ifdef SHA3_CTRL_ABORT_EN
        // abort in PERM is held until perm_done
        clear_log();
        for (int i = 0; i < 34; i++) send_beat(32'h5000_0000 + 32'(i), 3'd4, 1'b0);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();
        chk("abort_hold_clr", 64'(bus.state_clr), 64'd0);
        chk("abort_hold_rdy", 64'(bus.in_ready), 64'd0);
        bus.perm_done = 1'b1;
        tick();
        bus.perm_done = 1'b0;
        chk("abort_clr", 64'(bus.state_clr), 64'd1);
        tick();
        chk("abort_rdy", 64'(bus.in_ready), 64'd1);
        chk("abort_nstart", 64'(n_start), 64'd1);
`endif

        // recovery: a fresh message starts at word 0
        clear_log();
        send_beat(32'h0000_0061, 3'd1, 1'b1);
        run_perm(0, 1, "rec");
        chk_wr("rec_w0", 0, 0, 32'h0000_0661);
        chk_wr("rec_w1", 1, 33, 32'h8000_0000);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
